// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle signed 8-bit multiply/divide unit
module mdu (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic        [1:0] op_i,
    input  logic signed [7:0] rd_data_i,
    input  logic signed [7:0] rs_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_en_o,
    output logic signed [7:0] result_o,
    output logic              div_zero_o
);

    localparam int pico_N = 8;
    localparam int ITER   = pico_N;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              op_q;
    logic [pico_N-1:0]       a_mag, b_mag;
    logic                    a_neg, b_neg;
    logic [2:0]              cnt;
    logic [2*pico_N-1:0]     prod, prod_nxt, prod_s;
    logic [pico_N-1:0]       rem, rem_nxt, rem_s;
    logic [pico_N-1:0]       quo, quo_nxt, quo_s;
    logic [pico_N:0]         trial;
    logic                    b_zero;
    logic                    accept;
    logic                    last;
    logic [pico_N-1:0]       res_fin;
    logic                    dz_fin;

    // A new request is taken in IDLE and also in DONE (back-to-back issue).
    assign accept = start_i && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == 3'(ITER - 1));
    assign busy_o = (state == RUN);
    assign b_zero = (b_mag == '0);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (last)    state_nxt = DONE;
            DONE:    state_nxt = start_i ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shift-add step and one restoring-division step per cycle on the magnitudes.
    always_comb begin
        prod_nxt = prod + (b_mag[cnt] ? ({8'h00, a_mag} << cnt) : 16'h0000);
        trial    = {rem, a_mag[3'd7 - cnt]};
        rem_nxt  = trial[pico_N-1:0];
        quo_nxt  = {quo[pico_N-2:0], 1'b0};
        if (trial >= {1'b0, b_mag}) begin
            rem_nxt = 8'(trial - {1'b0, b_mag});
            quo_nxt = {quo[pico_N-2:0], 1'b1};
        end
    end

    // Sign correction of the final step; remainder follows the dividend's sign.
    always_comb begin
        prod_s  = (a_neg ^ b_neg) ? (16'h0000 - prod_nxt) : prod_nxt;
        quo_s   = (a_neg ^ b_neg) ? (8'h00 - quo_nxt) : quo_nxt;
        rem_s   = a_neg ? (8'h00 - rem_nxt) : rem_nxt;
        dz_fin  = op_q[1] && b_zero;
        case (op_q)
            OP_MUL:  res_fin = prod_s[pico_N-1:0];
            OP_MULH: res_fin = prod_s[2*pico_N-1:pico_N];
            OP_DIV:  res_fin = b_zero ? 8'hFF : quo_s;
            default: res_fin = rem_s;
        endcase
    end

    // Operand capture, iteration registers and registered result/strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= 2'b00;
            a_mag      <= '0;
            b_mag      <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            cnt        <= 3'd0;
            prod       <= '0;
            rem        <= '0;
            quo        <= '0;
            result_o   <= '0;
            done_o     <= 1'b0;
            wr_en_o    <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            wr_en_o    <= 1'b0;
            div_zero_o <= 1'b0;
            if (accept) begin
                op_q  <= op_i;
                a_neg <= rd_data_i[7];
                b_neg <= rs_data_i[7];
                a_mag <= rd_data_i[7] ? 8'(8'h00 - rd_data_i) : rd_data_i;
                b_mag <= rs_data_i[7] ? 8'(8'h00 - rs_data_i) : rs_data_i;
                cnt   <= 3'd0;
                prod  <= '0;
                rem   <= '0;
                quo   <= '0;
            end else if (state == RUN) begin
                prod <= prod_nxt;
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                cnt  <= cnt + 3'd1;
                if (last) begin
                    result_o   <= res_fin;
                    done_o     <= 1'b1;
                    wr_en_o    <= 1'b1;
                    div_zero_o <= dz_fin;
                end
            end
        end
    end

endmodule
